// File: rtl/booth4_acc_pkg.sv
// Shared definitions for the booth4 product accumulator.
//  - Default widths: PW (product), AW (accumulator), CNTW (length/counter).
//  - FSM state encoding shared by the top level.
package booth4_acc_pkg;

  localparam int unsigned PwDefault   = 16;
  localparam int unsigned AwDefault   = 20;
  localparam int unsigned CntwDefault = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/booth4_acc_sat_add.sv
// Combinational signed add of an AW-bit accumulator and a PW-bit product.
//  a_i   : AW-bit two's complement accumulator value
//  b_i   : PW-bit two's complement product (sign-extended internally)
//  sum_o : AW-bit result (wrapped, or clamped when ACC_SAT_EN is defined)
//  ovf_o : signed overflow of this add
// Optional feature: `ACC_SAT_EN clamps the result to +max/-min on overflow.
module booth4_acc_sat_add
  import booth4_acc_pkg::*;
#(
  parameter int unsigned PW = PwDefault,
  parameter int unsigned AW = AwDefault
) (
  input  logic [AW-1:0] a_i,
  input  logic [PW-1:0] b_i,
  output logic [AW-1:0] sum_o,
  output logic          ovf_o
);

  logic [AW-1:0] b_ext;
  logic [AW-1:0] raw_sum;

  assign b_ext   = {{(AW-PW){b_i[PW-1]}}, b_i};
  assign raw_sum = a_i + b_ext;

  // Overflow only when both operands share a sign and the sum's sign flips.
  assign ovf_o = (a_i[AW-1] == b_ext[AW-1]) && (raw_sum[AW-1] != a_i[AW-1]);

`ifdef ACC_SAT_EN
  always_comb begin
    sum_o = raw_sum;
    if (ovf_o) begin
      // Sign of the operands tells which rail was crossed.
      sum_o = a_i[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
  end
`else
  assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/booth4_acc.sv
// Accumulates a host-specified number of signed booth4 products into a signed
// AW-bit sum and returns it over a valid/ready handshake.
//  clk, rst_n            : clock, asynchronous active-low reset
//  start, len            : begin a run of len products (sampled only in idle)
//  prod_valid/prod_ready : upstream product handshake, prod is PW-bit signed
//  acc/acc_valid/acc_ready : result handshake, acc is AW-bit signed
//  ovf                   : sticky signed overflow for the current run
//  busy                  : run in progress or result pending
// Optional feature: define ACC_SAT_EN to saturate instead of wrapping.
module booth4_acc
  import booth4_acc_pkg::*;
#(
  parameter int unsigned PW   = PwDefault,
  parameter int unsigned AW   = AwDefault,
  parameter int unsigned CNTW = CntwDefault
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CNTW-1:0] len,
  input  logic            prod_valid,
  input  logic [PW-1:0]   prod,
  output logic            prod_ready,
  output logic [AW-1:0]   acc,
  output logic            acc_valid,
  input  logic            acc_ready,
  output logic            ovf,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic [AW-1:0]   add_sum;
  logic            add_ovf;

  booth4_acc_sat_add #(
    .PW (PW),
    .AW (AW)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (prod),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = StAccum;
          end else begin
            state_d = StDone;
          end
        end
      end
      StAccum: begin
        // prod_ready is implied by being in this state.
        if (prod_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (acc_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode the registered state only.
  assign prod_ready = (state_q == StAccum);
  assign acc_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign acc        = acc_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_booth4_acc.sv
module tb_booth4_acc;

  localparam int PW   = 16;
  localparam int AW   = 20;
  localparam int CNTW = 8;
  localparam longint AMAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (AW - 1));
  localparam longint AMOD = longint'(1) <<< AW;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [CNTW-1:0] len;
  logic            prod_valid;
  logic [PW-1:0]   prod;
  logic            prod_ready;
  logic [AW-1:0]   acc;
  logic            acc_valid;
  logic            acc_ready;
  logic            ovf;
  logic            busy;

  booth4_acc #(
    .PW   (PW),
    .AW   (AW),
    .CNTW (CNTW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .acc        (acc),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .ovf        (ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] acc;
    logic          ovf;
  } exp_t;

  exp_t          sb[$];
  logic [PW-1:0] src[$];
  int            n_total = 0;
  int            n_pass  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle a result is presented it must match the head of the
  // scoreboard; the entry retires when the downstream side takes it.
  always @(negedge clk) begin
    if (rst_n && acc_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_acc_valid", 1, 0);
      end else begin
        chk("acc", longint'(acc), longint'(sb[0].acc));
        chk("ovf", longint'(ovf), longint'(sb[0].ovf));
        chk("prod_ready_in_done", longint'(prod_ready), 0);
        if (acc_ready) void'(sb.pop_front());
      end
    end
  end

  // Reference: exact integer sum, with overflow judged against the signed
  // AW-bit range after every add.
  task automatic model_add(inout longint m_acc, inout bit m_ovf, input logic [PW-1:0] p);
    longint s;
    s = m_acc + longint'($signed(p));
    if (s > AMAX || s < AMIN) begin
      m_ovf = 1'b1;
`ifdef ACC_SAT_EN
      s = (s > AMAX) ? AMAX : AMIN;
`else
      s = (s > AMAX) ? s - AMOD : s + AMOD;
`endif
    end
    m_acc = s;
  endtask

  task automatic run(input int l, input int bubble_pct, input int hold, input bit mid_start);
    longint        m_acc = 0;
    bit            m_ovf = 1'b0;
    int            n = 0;
    int            guard = 0;
    logic [PW-1:0] pv;
    exp_t          e;
    while (busy && guard < 200) begin
      step();
      guard++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    start      = 1'b1;
    len        = CNTW'(l);
    prod_valid = 1'b1;
    prod       = PW'($urandom);
    if (l == 0) begin
      e.acc = '0;
      e.ovf = 1'b0;
      sb.push_back(e);
    end
    step();
    start = 1'b0;
    len   = CNTW'($urandom);
    if (l == 0) begin
      chk("zero_len_latency", longint'(acc_valid), 1);
    end else begin
      guard = 0;
      while (n < l && guard < 4000) begin
        prod_valid = ($urandom_range(0, 99) >= bubble_pct);
        pv         = (src.size() > 0) ? src[0] : PW'($urandom);
        prod       = pv;
        start      = mid_start && ($urandom_range(0, 3) == 0);
        if (prod_valid) begin
          chk("prod_ready_in_accum", longint'(prod_ready), 1);
          model_add(m_acc, m_ovf, pv);
          if (src.size() > 0) void'(src.pop_front());
          n++;
          if (n == l) begin
            e.acc = m_acc[AW-1:0];
            e.ovf = m_ovf;
            sb.push_back(e);
          end
        end
        step();
        guard++;
      end
      if (n < l) chk("accum_timeout", n, l);
      else chk("latency", longint'(acc_valid), 1);
    end
    start = 1'b0;
    for (int c = 0; c <= hold; c++) begin
      acc_ready  = (c == hold);
      start      = (c == hold) && mid_start;
      prod_valid = $urandom_range(0, 1) == 1;
      prod       = PW'($urandom);
      step();
    end
    acc_ready  = 1'b0;
    start      = 1'b0;
    prod_valid = 1'b0;
    chk("release_valid", longint'(acc_valid), 0);
    chk("release_busy", longint'(busy), 0);
    step();
    chk("start_in_done_ignored", longint'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    prod_valid = 1'b0;
    prod       = '0;
    acc_ready  = 1'b0;
    step();
    chk("rst_acc", longint'(acc), 0);
    chk("rst_acc_valid", longint'(acc_valid), 0);
    chk("rst_prod_ready", longint'(prod_ready), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_busy", longint'(busy), 0);
    rst_n = 1'b1;
    step();

    // Basic three-product run.
    src = {16'h0CA8, 16'hFFFF, 16'h0002};
    run(3, 0, 0, 1'b0);
    // Seventeen max-positive products overflow the accumulator.
    repeat (17) src.push_back(16'h7FFF);
    run(17, 0, 0, 1'b0);
    // Five cycles of backpressure on the result.
    run(2, 0, 5, 1'b0);
    // Zero-length run.
    run(0, 0, 1, 1'b0);
    // Bubbles with ignored start pulses.
    src = {16'h0011, 16'h0022};
    run(2, 50, 0, 1'b1);
    // Max-negative products toward the lower rail.
    repeat (20) src.push_back(16'h8000);
    run(20, 20, 2, 1'b1);

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    len   = CNTW'(5);
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 16'h1234;
    step();
    step();
    prod_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc", longint'(acc), 0);
    chk("arst_acc_valid", longint'(acc_valid), 0);
    chk("arst_prod_ready", longint'(prod_ready), 0);
    chk("arst_ovf", longint'(ovf), 0);
    chk("arst_busy", longint'(busy), 0);
    step();
    #2 rst_n = 1'b1;
    step();
    src = {16'h8000};
    run(1, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run($urandom_range(0, 20), $urandom_range(0, 60), $urandom_range(0, 3),
          $urandom_range(0, 1) == 1);
    end
    run(255, 10, 1, 1'b1);

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
